// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the EX-stage ALU decoder and the optional
// sequential multiply/divide unit.
//   - single-cycle ALU select codes driven on alu_opcode
//   - funct3 encodings of the M-extension ops
//   - funct7 class constants
//   - FSM state encoding for the MDU sequencer
// The MDU is only built when the macro ALU_SEQ_MDU_EN is defined.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MDU  = 7'b0000001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide datapath, one step per cycle.
// Built only when ALU_SEQ_MDU_EN is defined.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load operands (magnitudes) and op
//   abort         clear internal state (pipeline flush)
//   step          perform one shift-add / restoring-subtract step
//   op, a, b      funct3 and raw operands (sampled on start)
//   special       divide-by-zero or signed overflow for the current inputs
//   special_res   result for the special case
//   res_next      sign-corrected result as it will be after this step
`ifdef ALU_SEQ_MDU_EN
module mdu_iter
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic            step,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            special,
   output logic [XLEN-1:0] special_res,
   output logic [XLEN-1:0] res_next
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   // hi/lo: product halves for multiply; remainder/quotient for divide
   logic [XLEN-1:0] hi_q, lo_q, dv_q;
   logic [2:0]      op_q;
   logic            neg_q;

   logic            a_sgn, b_sgn, a_neg, b_neg, dz, ovf;
   logic [XLEN-1:0] a_mag, b_mag;

   always_comb begin
      a_sgn = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
      b_sgn = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
      a_neg = a_sgn & a[XLEN-1];
      b_neg = b_sgn & b[XLEN-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
      dz    = op[2] && (b == '0);
      ovf   = ((op == MDU_DIV) || (op == MDU_REM)) && (a == MOST_NEG) && (b == '1);
      special     = dz | ovf;
      special_res = '0;
      if (dz)
         special_res = op[1] ? a : '1;
      else if (ovf)
         special_res = op[1] ? '0 : MOST_NEG;
   end

   logic [XLEN:0]     sum, rsh;
   logic [XLEN-1:0]   rdiff, hi_n, lo_n, quo_s, rem_s;
   logic [2*XLEN-1:0] prod, prod_s;

   always_comb begin
      hi_n  = hi_q;
      lo_n  = lo_q;
      sum   = '0;
      rsh   = '0;
      rdiff = '0;
      if (!op_q[2]) begin
         // shift-add: multiplier sits in lo and shifts out LSB first
         sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo_q[XLEN-1:1]};
      end else begin
         // restoring division: dividend shifts out of lo into hi
         rsh   = {hi_q, lo_q[XLEN-1]};
         rdiff = rsh[XLEN-1:0] - dv_q;
         if (rsh >= {1'b0, dv_q}) begin
            hi_n = rdiff;
            lo_n = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_n = rsh[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b0};
         end
      end

      prod   = {hi_n, lo_n};
      prod_s = neg_q ? -prod : prod;
      quo_s  = neg_q ? -lo_n : lo_n;
      rem_s  = neg_q ? -hi_n : hi_n;
      case (op_q)
         MDU_MUL:                          res_next = prod_s[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU:  res_next = prod_s[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:                res_next = quo_s;
         default:                          res_next = rem_s;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         hi_q  <= '0;
         lo_q  <= '0;
         dv_q  <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
      end else if (start) begin
         hi_q  <= '0;
         lo_q  <= a_mag;
         dv_q  <= b_mag;
         op_q  <= op;
         // remainder sign follows the dividend only
         neg_q <= (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
      end else if (step) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
      end
   end

endmodule
`endif

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: EX-stage ALU control decoder with an optional sequential
// multiply/divide unit (enabled by defining ALU_SEQ_MDU_EN).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i             EX-stage instruction valid
//   ALUop               00 R-type, 01 I-type ALU, 1x forced add
//   funct3, funct7      instruction fields
//   kill_i              pipeline flush, aborts a multi-cycle op
//   src_a, src_b        operands
//   alu_opcode          single-cycle ALU select (combinational)
//   ready_o             MDU idle
//   stall_o             hold the pipeline while the MDU accepts/works
//   done_o              one-cycle pulse, result_o valid
//   illegal_o           unsupported funct7/funct3 combination
//   result_o            MDU result, held outside DONE
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [1:0]      ALUop,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic            kill_i,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic [3:0]      alu_opcode,
   output logic            ready_o,
   output logic            stall_o,
   output logic            done_o,
   output logic            illegal_o,
   output logic [XLEN-1:0] result_o
);

   logic mdu_f7, legal_f7;

   always_comb begin
      mdu_f7     = (funct7 == F7_MDU);
      alu_opcode = ALU_ADD;
      if (!ALUop[1]) begin
         case (funct3)
            3'b000:  alu_opcode = ((ALUop == 2'b00) && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_opcode = ALU_SLL;
            3'b010:  alu_opcode = ALU_SLT;
            3'b011:  alu_opcode = ALU_SLTU;
            3'b100:  alu_opcode = ALU_XOR;
            3'b101:  alu_opcode = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_opcode = ALU_OR;
            default: alu_opcode = ALU_AND;
         endcase
      end
`ifndef ALU_SEQ_MDU_EN
      if ((ALUop == 2'b00) && mdu_f7)
         alu_opcode = ALU_ADD;
`endif

      legal_f7 = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
`ifdef ALU_SEQ_MDU_EN
      if (mdu_f7)
         legal_f7 = 1'b1;
`endif
      illegal_o = valid_i && (ALUop == 2'b00) && !legal_f7;
   end

`ifdef ALU_SEQ_MDU_EN
   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] LAST = '1;

   mdu_state_t      state_q;
   logic [CW-1:0]   cnt_q;
   logic            ready_q, done_q, busy_q;
   logic [XLEN-1:0] result_q;

   logic            mdu_op, accept, special;
   logic [XLEN-1:0] special_res, res_next;

   always_comb begin
      mdu_op  = (ALUop == 2'b00) && mdu_f7;
      accept  = (state_q == ST_IDLE) && valid_i && mdu_op && !kill_i && !rst;
      stall_o = accept | busy_q;
   end

   mdu_iter #(.XLEN(XLEN)) u_mdu (
      .clk         (clk),
      .rst         (rst),
      .start       (accept),
      .abort       (kill_i),
      .step        (busy_q),
      .op          (funct3),
      .a           (src_a),
      .b           (src_b),
      .special     (special),
      .special_res (special_res),
      .res_next    (res_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         result_q <= '0;
      end else if (kill_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  ready_q <= 1'b0;
                  if (special) begin
                     state_q  <= ST_DONE;
                     done_q   <= 1'b1;
                     result_q <= special_res;
                  end else begin
                     state_q <= ST_BUSY;
                     busy_q  <= 1'b1;
                     cnt_q   <= '0;
                  end
               end
            end
            ST_BUSY: begin
               // the last step's outcome is captured in the same edge it is computed
               if (cnt_q == LAST) begin
                  state_q  <= ST_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= res_next;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign done_o   = done_q;
   assign result_o = result_q;
`else
   logic unused_ok;
   assign unused_ok = ^{clk, rst, kill_i, src_a, src_b};
   assign ready_o   = 1'b1;
   assign stall_o   = 1'b0;
   assign done_o    = 1'b0;
   assign result_o  = '0;
`endif

endmodule
